hsv_deserializer: RTL and testbench
===================================

HSV_DESERIALIZER -- requirements
Module: hsv_deserializer

Interface
REQ-001 SHALL have parameter PIX_BITS, default 24, bits per HSV pixel word.
REQ-002 SHALL have parameter FRAME_PIXELS, default LENGTH*WIDTH, pixels per frame.
REQ-003 SHALL have parameter FILTER_LEN, default 4, glitch-filter stability length in fpga_clk cycles.
REQ-004 SHALL have port fpga_clk, input, 1, sole clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pi_clk, input, 1, Raspberry Pi bit clock, asynchronous to fpga_clk.
REQ-007 SHALL have port data_in, input, 1, serial bit, sampled on pi_clk rising edge, asynchronous.
REQ-008 SHALL have port write_enable, input, 1, frame gate, asynchronous.
REQ-009 SHALL have port pix_ready, input, 1, downstream accepts the pixel word.
REQ-010 SHALL have port pix_valid, output, 1, pix_data holds a complete word.
REQ-011 SHALL have port pix_data, output, PIX_BITS, the HSV word: [7:0] hue, [15:8] saturation, [23:16] value.
REQ-012 SHALL have port pix_last, output, 1, qualifies pix_valid as the final pixel of a frame.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse when the last pixel is accepted.
REQ-014 SHALL have port overrun, output, 1, sticky: a completed word was dropped.

Function
REQ-015 SHALL pass pi_clk, data_in and write_enable each through a two-flop synchronizer.
REQ-016 SHALL detect a pi_clk rising edge as synchronized pi_clk high while its previous-cycle value is low.
REQ-017 SHALL use FSM states IDLE, SHIFT and HOLD.
REQ-018 IDLE: SHALL move to SHIFT when synchronized write_enable is 1; bit count is 0.
REQ-019 SHIFT: SHALL write synchronized data_in into shift[bit_cnt] on each detected edge, so the first bit lands in the LSB, then increment bit_cnt.
REQ-020 SHALL, on the edge carrying bit PIX_BITS-1, load the word into the output register, clear bit_cnt and go to HOLD; pix_valid SHALL rise the next cycle.
REQ-021 HOLD: SHALL keep shifting incoming bits. SHALL drop pix_valid the cycle after pix_valid&&pix_ready, then return to SHIFT.
REQ-022 SHALL, if a second word completes while pix_valid=1 and pix_ready=0, discard the new word, keep the held word and set overrun.
REQ-023 SHALL, on a simultaneous accept and completion, load the new word and keep pix_valid=1 with no overrun.
REQ-024 SHALL keep a pixel counter of width $clog2(FRAME_PIXELS) that increments on each accepted word.
REQ-025 pix_last SHALL equal pix_valid && (pixel counter == FRAME_PIXELS-1).
REQ-026 SHALL, on acceptance of the last pixel, pulse frame_done for 1 cycle and wrap the pixel counter to 0.
REQ-027 SHALL, when synchronized write_enable falls mid-word, discard the partial word, clear bit_cnt and go to IDLE.
REQ-028 SHALL keep a held valid word and the pixel counter unchanged when write_enable falls.
REQ-029 SHALL ignore edges detected while in IDLE.

Reset
REQ-030 SHALL, while rst_n=0, hold the FSM in IDLE.
REQ-031 SHALL clear bit_cnt, the pixel counter, the shift register, the synchronizers and the filter state while rst_n=0.
REQ-032 Output reset values SHALL be: pix_valid=0, pix_data=0, pix_last=0, frame_done=0, overrun=0.
REQ-033 A reset mid-word or mid-frame SHALL drop all partial state; the first edge after release SHALL be bit 0.

Configuration
REQ-034 With HSV_DESER_FILTER_EN defined, the synchronized pi_clk SHALL change filtered level only after FILTER_LEN consecutive equal samples, adding FILTER_LEN cycles of edge latency.
REQ-035 With HSV_DESER_FILTER_EN defined, pulses shorter than FILTER_LEN cycles SHALL be ignored.
REQ-036 Without HSV_DESER_FILTER_EN, edge detection SHALL use the two-flop output directly and SHALL have no filter logic.

Structure
REQ-037 LENGTH, WIDTH, PIX_BITS and the FSM state enum SHALL live in the shared package neuralnet_pkg.
REQ-038 The hue, saturation and value field offsets SHALL also live in neuralnet_pkg.
REQ-039 Sub-module sync_filter SHALL implement one two-flop synchronizer plus the optional filter, instantiated three times.

Verification
REQ-040 Send 24 bits forming 0x3C8012, LSB first, with pix_ready=1 -> pix_valid for exactly 1 cycle, pix_data=0x3C8012, overrun=0.
REQ-041 Hold pix_ready=0 while two words stream in -> first word held, second dropped, overrun=1 sticky until rst_n.
REQ-042 Deassert write_enable after 10 bits, then reassert and send 0x0000FF -> pix_data=0x0000FF; no stale bits.
REQ-043 Stream FRAME_PIXELS words -> pix_last only on the final word, frame_done pulses once, the counter wraps, and the next word is pixel 0.
REQ-044 With HSV_DESER_FILTER_EN, inject a 2-cycle pi_clk glitch -> no bit captured; without the macro, the same glitch captures a bit.
REQ-045 Assert rst_n=0 after 12 bits -> all outputs 0 immediately; the next 24 bits form a correct word.

Source files
------------

// File: rtl/neuralnet_pkg.sv
// Shared types and constants for the HSV pixel deserializer.
// Frame geometry, pixel word layout and FSM state encoding.
package neuralnet_pkg;

  localparam int LENGTH = 8;
  localparam int WIDTH = 8;
  localparam int PIX_BITS = 24;

  localparam int FIELD_BITS = 8;
  localparam int HUE_LSB = 0;
  localparam int SAT_LSB = 8;
  localparam int VAL_LSB = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } deser_state_t;

  function automatic logic [PIX_BITS-1:0] hsv_pack(
    input logic [FIELD_BITS-1:0] hue,
    input logic [FIELD_BITS-1:0] sat,
    input logic [FIELD_BITS-1:0] val
  );
    logic [PIX_BITS-1:0] w;
    w = '0;
    w[HUE_LSB +: FIELD_BITS] = hue;
    w[SAT_LSB +: FIELD_BITS] = sat;
    w[VAL_LSB +: FIELD_BITS] = val;
    return w;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer; with HSV_DESER_FILTER_EN the output level
// only follows after FILTER_LEN consecutive equal samples.
module sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], din};
    end
  end

`ifdef HSV_DESER_FILTER_EN
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CW-1:0] cnt;
  logic          level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      level <= sync[1];
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign q = level;
`else
  assign q = sync[1];
`endif

  if (FILTER_LEN < 1) begin : g_len_chk
    $error("sync_filter: FILTER_LEN must be at least 1");
  end

endmodule

// File: rtl/hsv_deserializer.sv
// Serial-to-parallel HSV pixel receiver with valid/ready output.
// Define HSV_DESER_FILTER_EN to glitch-filter the synchronized inputs.
module hsv_deserializer
  import neuralnet_pkg::*;
#(
  parameter int PIX_BITS = neuralnet_pkg::PIX_BITS,
  parameter int FRAME_PIXELS = LENGTH * WIDTH,
  parameter int FILTER_LEN = 4
) (
  input  logic                fpga_clk,
  input  logic                rst_n,
  input  logic                pi_clk,
  input  logic                data_in,
  input  logic                write_enable,
  input  logic                pix_ready,
  output logic                pix_valid,
  output logic [PIX_BITS-1:0] pix_data,
  output logic                pix_last,
  output logic                frame_done,
  output logic                overrun
);

  localparam int BW = $clog2(PIX_BITS);
  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PIX_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  logic pclk_s;
  logic data_s;
  logic we_s;
  logic pclk_d;
  logic edge_p;

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_pclk (
    .clk  (fpga_clk),
    .rst_n(rst_n),
    .din  (pi_clk),
    .q    (pclk_s)
  );

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_data (
    .clk  (fpga_clk),
    .rst_n(rst_n),
    .din  (data_in),
    .q    (data_s)
  );

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_we (
    .clk  (fpga_clk),
    .rst_n(rst_n),
    .din  (write_enable),
    .q    (we_s)
  );

  assign edge_p = pclk_s & ~pclk_d;

  deser_state_t state;
  deser_state_t state_next;

  logic [PIX_BITS-1:0] shift;
  logic [BW-1:0]       bit_cnt;
  logic [CNT_W-1:0]    pix_cnt;

  logic capture;
  logic complete;
  logic accept;
  logic load;
  logic drop;
  logic valid_next;
  logic last_hit;

  assign capture  = (state != IDLE) & we_s & edge_p;
  assign complete = capture & (bit_cnt == LAST_BIT);
  assign accept   = pix_valid & pix_ready;
  assign load     = complete & (~pix_valid | accept);
  assign drop     = complete & pix_valid & ~pix_ready;
  assign last_hit = pix_cnt == LAST_PIX;
  assign pix_last = pix_valid & last_hit;

  always_comb begin
    valid_next = pix_valid;
    if (load) begin
      valid_next = 1'b1;
    end else if (accept) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (we_s) begin
          state_next = valid_next ? HOLD : SHIFT;
        end
      end
      SHIFT, HOLD: begin
        if (!we_s) begin
          state_next = IDLE;
        end else begin
          state_next = valid_next ? HOLD : SHIFT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_d     <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pclk_d     <= pclk_s;
      pix_valid  <= valid_next;
      frame_done <= accept & last_hit;
      if (!we_s) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (capture) begin
        shift[bit_cnt] <= data_s;
        bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
      end
      // The final bit bypasses the shift register into the word.
      if (load) begin
        pix_data <= {data_s, shift[PIX_BITS-2:0]};
      end
      if (drop) begin
        overrun <= 1'b1;
      end
      if (accept) begin
        pix_cnt <= last_hit ? '0 : pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hsv_deserializer.sv
// Scoreboard bench for hsv_deserializer: directed serial words,
// a monitor pops expected pixels on every accepted handshake.
module tb_hsv_deserializer;
  import neuralnet_pkg::*;

  localparam int FP = 4;

  logic        fpga_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pi_clk = 1'b0;
  logic        data_in = 1'b0;
  logic        write_enable = 1'b0;
  logic        pix_ready = 1'b1;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        frame_done;
  logic        overrun;

  always #5 fpga_clk = ~fpga_clk;

  hsv_deserializer #(
    .PIX_BITS    (24),
    .FRAME_PIXELS(FP),
    .FILTER_LEN  (4)
  ) dut (
    .fpga_clk    (fpga_clk),
    .rst_n       (rst_n),
    .pi_clk      (pi_clk),
    .data_in     (data_in),
    .write_enable(write_enable),
    .pix_ready   (pix_ready),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  typedef struct packed {
    logic [23:0] d;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge fpga_clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (pix_valid && pix_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pix: got %h want none", pix_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pix_data", {8'h0, pix_data}, {8'h0, e.d});
          check("pix_last", {31'h0, pix_last}, {31'h0, e.l});
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge fpga_clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    cyc(3);
    pi_clk = 1'b1;
    cyc(8);
    pi_clk = 1'b0;
    cyc(8);
  endtask

  task automatic send_range(input logic [23:0] w, input int lo,
                            input int hi);
    for (int i = lo; i <= hi; i++) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [23:0] w, input logic last);
    q.push_back('{d: w, l: last});
    send_range(w, 0, 23);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, {31'h0, pix_valid}, 32'h0);
    check({tag, "_data"}, {8'h0, pix_data}, 32'h0);
    check({tag, "_last"}, {31'h0, pix_last}, 32'h0);
    check({tag, "_fdone"}, {31'h0, frame_done}, 32'h0);
    check({tag, "_ovr"}, {31'h0, overrun}, 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    check_zero_outputs("rst");
    rst_n = 1'b1;
    write_enable = 1'b1;
    cyc(10);

    // Basic word, pixel 0.
    send_word(hsv_pack(8'h12, 8'h80, 8'h3C), 1'b0);
    cyc(5);
    check("basic_ovr", {31'h0, overrun}, 32'h0);
    check("basic_valid_drop", {31'h0, pix_valid}, 32'h0);

    // Partial word aborted by write_enable, then pixel 1.
    send_range(24'hABC, 0, 9);
    write_enable = 1'b0;
    cyc(10);
    write_enable = 1'b1;
    cyc(10);
    send_word(24'h0000FF, 1'b0);

    // Finish the frame, then the counter wraps to pixel 0.
    send_word(24'h111111, 1'b0);
    send_word(24'h222222, 1'b1);
    cyc(5);
    check("frame_done_1", fd_cnt, 32'd1);
    send_word(24'h333333, 1'b0);
    cyc(5);
    check("frame_done_once", fd_cnt, 32'd1);

    // Back-pressure: second word dropped, first held (pixel 1).
    pix_ready = 1'b0;
    send_range(24'hA5A5A5, 0, 23);
    send_range(24'h5A5A5A, 0, 23);
    cyc(5);
    check("ovr_valid", {31'h0, pix_valid}, 32'h1);
    check("ovr_held", {8'h0, pix_data}, 32'hA5A5A5);
    check("ovr_set", {31'h0, overrun}, 32'h1);
    check("ovr_last", {31'h0, pix_last}, 32'h0);
    q.push_back('{d: 24'hA5A5A5, l: 1'b0});
    pix_ready = 1'b1;
    cyc(3);
    check("ovr_drain_valid", {31'h0, pix_valid}, 32'h0);
    check("ovr_drain_q", q.size(), 32'd0);

    // Short pi_clk glitch carrying a 1, then pixel 2.
    data_in = 1'b1;
    cyc(3);
    pi_clk = 1'b1;
    cyc(2);
    pi_clk = 1'b0;
    cyc(8);
    data_in = 1'b0;
`ifdef HSV_DESER_FILTER_EN
    send_word(24'h123456, 1'b0);
`else
    q.push_back('{d: 24'h123457, l: 1'b0});
    send_range(24'h123456, 1, 23);
`endif
    cyc(5);
    check("ovr_sticky", {31'h0, overrun}, 32'h1);
    check("glitch_q", q.size(), 32'd0);

    // Reset mid-word drops everything, counter restarts.
    send_range(24'hFFFFFF, 0, 11);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    send_word(24'hC0FFEE, 1'b0);
    send_word(24'h0F0F0F, 1'b0);
    send_word(24'hF0F0F0, 1'b0);
    send_word(24'h00A0B1, 1'b1);
    cyc(5);
    check("frame_done_2", fd_cnt, 32'd2);
    check("final_q", q.size(), 32'd0);
    check("final_ovr", {31'h0, overrun}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
